// File: rtl/order_mem_responder.sv
`default_nettype none
// +------------------------------------------------------------------------------+
// | order_mem_responder: fixed-latency single-request book_entry storage responder |
// | Rev 1.0                                                                      |
// +------------------------------------------------------------------------------+
module order_mem_responder #(
  parameter int PRICE_W       = 16,
  parameter int QTY_W         = 16,
  parameter int ADDRESS_INDEX = 4,
  parameter int MAX_INDEX     = 15,
  parameter int DEPTH         = MAX_INDEX + 1,
  parameter int LATENCY       = 2
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       mem_start,
  input  logic [ADDRESS_INDEX:0]     addr,
  input  logic                       is_write,
  input  logic [PRICE_W+QTY_W-1:0]   data_w,
  output logic                       valid,
  output logic [PRICE_W+QTY_W-1:0]   data_r,
  output logic                       ready_o,
  output logic                       addr_err,
  output logic                       dropped
);

  localparam int ENTRY_W = PRICE_W + QTY_W;
  localparam int ADDR_W  = ADDRESS_INDEX + 1;
  localparam int CNT_W   = $clog2(LATENCY + 1);
  localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]    DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0]   CNT_LOAD  = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);

  // The completion ("DONE") step is not a resting state: it is the edge that
  // leaves WAIT (or IDLE when LATENCY==1) and lands back in IDLE with valid set.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0]    req_addr_q, req_addr_d;
  logic                 req_wr_q, req_wr_d;
  logic [ENTRY_W-1:0]   req_data_q, req_data_d;
  logic                 valid_q, valid_d;
  logic [ENTRY_W-1:0]   data_r_q, data_r_d;
  logic                 addr_err_q, addr_err_d;
  logic                 dropped_q, dropped_d;
  logic [ENTRY_W-1:0]   mem_q [DEPTH];

  logic                 done;
  logic                 cur_wr;
  logic                 in_range;
  logic [ADDR_W-1:0]    cur_addr;
  logic [ENTRY_W-1:0]   cur_data;
  logic [IDX_W-1:0]     cur_idx;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_addr_d = req_addr_q;
    req_wr_d   = req_wr_q;
    req_data_d = req_data_q;
    done       = 1'b0;
    cur_addr   = req_addr_q;
    cur_wr     = req_wr_q;
    cur_data   = req_data_q;

    case (state_q)
      IDLE: begin
        if (mem_start) begin
          req_addr_d = addr;
          req_wr_d   = is_write;
          req_data_d = data_w;
          cnt_d      = CNT_LOAD;
          // Single-cycle latency completes on the accept edge straight from the inputs.
          if (LATENCY == 1) begin
            done     = 1'b1;
            cur_addr = addr;
            cur_wr   = is_write;
            cur_data = data_w;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_range   = ({1'b0, cur_addr} < DEPTH_EXT);
    cur_idx    = cur_addr[IDX_W-1:0];
    valid_d    = done;
    addr_err_d = done && !in_range;
    dropped_d  = mem_start && (state_q != IDLE);
    data_r_d   = (done && !cur_wr && in_range) ? mem_q[cur_idx] : data_r_q;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      req_addr_q <= '0;
      req_wr_q   <= 1'b0;
      req_data_q <= '0;
      valid_q    <= 1'b0;
      data_r_q   <= '0;
      addr_err_q <= 1'b0;
      dropped_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_addr_q <= req_addr_d;
      req_wr_q   <= req_wr_d;
      req_data_q <= req_data_d;
      valid_q    <= valid_d;
      data_r_q   <= data_r_d;
      addr_err_q <= addr_err_d;
      dropped_q  <= dropped_d;
    end
  end

  // Storage survives reset; an aborted request never reaches the completion edge.
  always_ff @(posedge clk_in) begin
    if (done && cur_wr && in_range) begin
      mem_q[cur_idx] <= cur_data;
    end
  end

  assign valid    = valid_q;
  assign data_r   = data_r_q;
  assign ready_o  = (state_q == IDLE);
  assign addr_err = addr_err_q;
  assign dropped  = dropped_q;

endmodule
`default_nettype wire
